// File: rtl/fetch_arb_pkg.sv
// Shared definitions for the instruction-memory fetch arbiter.
package fetch_arb_pkg;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_LD = 2'd2,
    ST_DRAIN   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/fetch_arbiter.sv
// Shares the single-ported instruction memory between the IF fetch port and the
// loader/debug port, one outstanding transaction at a time, with starvation guard.
module fetch_arbiter
  import fetch_arb_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic              if_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
  logic              ld_ack_q, ld_ack_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

  logic if_elig, ld_elig, grant_if, grant_ld;

  // A requester is not eligible in its own response-pulse cycle, since its request is still up.
  always_comb begin
    if_elig  = if_req & ~if_flush & ~if_valid_q;
    ld_elig  = ld_req & ~ld_ack_q;
    grant_ld = (state_q == ST_IDLE) & ld_elig & (~if_elig | (starve_cnt_q == STARVE_MAX));
    grant_if = (state_q == ST_IDLE) & if_elig & ~grant_ld;
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_valid_d   = 1'b0;
    if_instr_d   = if_instr_q;
    ld_ack_d     = 1'b0;
    ld_rdata_d   = ld_rdata_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_ld) begin
          state_d     = ST_BUSY_LD;
          mem_req_d   = 1'b1;
          mem_we_d    = ld_we;
          mem_addr_d  = ld_addr;
          mem_wdata_d = ld_wdata;
        end else if (grant_if) begin
          state_d     = ST_BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      ST_BUSY_IF: begin
        if (mem_ready) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          if (!if_flush) begin
            if_instr_d = mem_rdata;
            if_valid_d = 1'b1;
          end
        end else if (if_flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_BUSY_LD: begin
        if (mem_ready) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          ld_ack_d  = 1'b1;
          if (!mem_we_q) begin
            ld_rdata_d = mem_rdata;
          end
        end
      end
      ST_DRAIN: begin
        if (mem_ready) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // The guard only counts IF wins while the loader is actually waiting.
    if (!ld_req || grant_ld) begin
      starve_cnt_d = '0;
    end else if (grant_if && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      ld_ack_q     <= 1'b0;
      ld_rdata_q   <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      ld_ack_q     <= ld_ack_d;
      ld_rdata_q   <= ld_rdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign if_stall  = if_req & ~if_valid_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign ld_ack    = ld_ack_q;
  assign ld_rdata  = ld_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed bench for fetch_arbiter against a small wait-state memory model.
module tb_fetch_arbiter;
  import fetch_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        if_stall;
  logic        ld_req;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_ack;
  logic [31:0] ld_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_model [0:255];
  int wait_states = 0;
  int wait_cnt = 0;

  fetch_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_instr(if_instr), .if_stall(if_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers after wait_states cycles of mem_req; writes land on the ready edge.
  assign mem_ready = mem_req && (wait_cnt == wait_states);
  assign mem_rdata = mem_model[mem_addr[9:2]];

  always @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= 0;
    end else if (mem_ready) begin
      wait_cnt <= 0;
      if (mem_we) mem_model[mem_addr[9:2]] <= mem_wdata;
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
    mem_model[1]  = 32'h1111_1111;
    mem_model[2]  = 32'h3333_3333;
    mem_model[4]  = 32'h2008_0005;
    mem_model[16] = 32'h2222_2222;

    rst = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    tick(); tick();
    check_output("rst_mem_req", mem_req, 0);
    check_output("rst_mem_addr", mem_addr, 0);
    check_output("rst_if_valid", if_valid, 0);
    check_output("rst_ld_ack", ld_ack, 0);
    check_output("rst_state", dut.state_q, ST_IDLE);
    rst = 1'b1;
    tick();

    // Basic zero-wait fetch
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    check_output("basic_stall_T", if_stall, 1);
    tick();
    check_output("basic_mem_req_T1", mem_req, 1);
    check_output("basic_mem_addr_T1", mem_addr, 32'h10);
    check_output("basic_stall_T1", if_stall, 1);
    check_output("basic_no_valid_T1", if_valid, 0);
    tick();
    check_output("basic_valid_T2", if_valid, 1);
    check_output("basic_instr_T2", if_instr, 32'h2008_0005);
    check_output("basic_stall_T2", if_stall, 0);
    check_output("basic_mem_req_drop", mem_req, 0);
    if_req = 1'b0;
    tick();
    check_output("basic_valid_pulse_end", if_valid, 0);

    // Three wait states on address 0x4
    wait_states = 3;
    if_req = 1'b1; if_addr = 32'h4;
    tick();
    for (int i = 0; i < 4; i++) begin
      check_output("ws_mem_req", mem_req, 1);
      check_output("ws_mem_addr", mem_addr, 32'h4);
      check_output("ws_mem_we", mem_we, 0);
      check_output("ws_no_valid", if_valid, 0);
      tick();
    end
    check_output("ws_valid", if_valid, 1);
    check_output("ws_instr", if_instr, 32'h1111_1111);
    if_req = 1'b0;
    tick();
    check_output("ws_single_pulse", if_valid, 0);

    // Flush one cycle after grant, memory answers two cycles later
    wait_states = 2;
    if_req = 1'b1; if_addr = 32'h8;
    tick();
    check_output("fl_busy_req", mem_req, 1);
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0; if_addr = 32'h40;
    check_output("fl_state_drain", dut.state_q, ST_DRAIN);
    check_output("fl_drain_req", mem_req, 1);
    tick();
    check_output("fl_drain_hold_addr", mem_addr, 32'h8);
    check_output("fl_no_valid_a", if_valid, 0);
    tick();
    check_output("fl_idle_after_ready", dut.state_q, ST_IDLE);
    check_output("fl_req_low", mem_req, 0);
    check_output("fl_no_valid_b", if_valid, 0);
    wait_states = 0;
    tick();
    check_output("fl_new_req", mem_req, 1);
    check_output("fl_new_addr", mem_addr, 32'h40);
    tick();
    check_output("fl_new_valid", if_valid, 1);
    check_output("fl_new_instr", if_instr, 32'h2222_2222);
    if_req = 1'b0;
    tick();

    // A flush while idle holds off the IF grant for that cycle only
    if_req = 1'b1; if_addr = 32'h8; if_flush = 1'b1;
    tick();
    check_output("idle_flush_blocks", mem_req, 0);
    if_flush = 1'b0;
    tick();
    check_output("idle_flush_release", mem_req, 1);
    tick();
    check_output("idle_flush_instr", if_instr, 32'h3333_3333);
    if_req = 1'b0;
    tick();

    // Starvation: every fetch is flushed in its busy cycle so IF keeps re-winning
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h100; ld_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h10;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_output("st_if_grant_req", mem_req, 1);
      check_output("st_if_grant_we", mem_we, 0);
      check_output("st_if_grant_addr", mem_addr, 32'h10);
      if_flush = 1'b1;
      tick();
      if_flush = 1'b0;
      check_output("st_cnt", dut.starve_cnt_q, i + 1);
      check_output("st_no_valid", if_valid, 0);
    end
    tick();
    check_output("st_ld_grant_addr", mem_addr, 32'h100);
    check_output("st_ld_grant_we", mem_we, 1);
    check_output("st_ld_grant_wdata", mem_wdata, 32'hDEAD_BEEF);
    check_output("st_cnt_clear", dut.starve_cnt_q, 0);
    tick();
    check_output("st_ld_ack", ld_ack, 1);
    ld_req = 1'b0; if_req = 1'b0;
    tick();
    check_output("st_ld_ack_end", ld_ack, 0);
    check_output("st_mem_written", mem_model[64], 32'hDEAD_BEEF);

    // Loader read with a flush during BUSY_LD
    wait_states = 1;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h100;
    tick();
    check_output("lr_req", mem_req, 1);
    check_output("lr_we", mem_we, 0);
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0;
    check_output("lr_flush_ignored", dut.state_q, ST_BUSY_LD);
    tick();
    check_output("lr_ack", ld_ack, 1);
    check_output("lr_rdata", ld_rdata, 32'hDEAD_BEEF);
    ld_req = 1'b0;
    tick();
    check_output("lr_ack_end", ld_ack, 0);

    // Reset during BUSY_IF
    wait_states = 3;
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    check_output("rm_busy", dut.state_q, ST_BUSY_IF);
    rst = 1'b0;
    tick();
    check_output("rm_state", dut.state_q, ST_IDLE);
    check_output("rm_mem_req", mem_req, 0);
    check_output("rm_mem_addr", mem_addr, 0);
    check_output("rm_if_instr", if_instr, 0);
    check_output("rm_ld_rdata", ld_rdata, 0);
    check_output("rm_stall_follows_req", if_stall, 1);
    rst = 1'b1; if_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
